pwm_peripheral: RTL
===================

Name: pwm_peripheral

Overview:
- Consumes the five configuration registers written over SPI and drives the 16 chip outputs: uo_out[7:0] on out[7:0], uio_out[7:0] on out[15:8].
- Each output is forced low, held high, or driven by one shared PWM waveform whose duty is set by pwm_duty_cycle.
- Contains a prescaled 8-bit timebase and a registered output mask stage.
- Optionally shadows the duty value so that duty changes take effect only at a period boundary.

Parameters:
- PRESCALE, 13, clk cycles per PWM counter step. Legal range 1..65535. PWM period = 256*PRESCALE clk cycles.
- PRESCALE_W, 16, width of the prescaler counter. Must satisfy 2^PRESCALE_W >= PRESCALE.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en_reg_out_7_0  input  8  output enable, out[7:0]
- en_reg_out_15_8  input  8  output enable, out[15:8]
- en_reg_pwm_7_0  input  8  PWM select, out[7:0]
- en_reg_pwm_15_8  input  8  PWM select, out[15:8]
- pwm_duty_cycle  input  8  duty, 0x00 = 0%, 0xFF = 100%
- out  output  16  registered pin drive
- period_start  output  1  one-cycle pulse on the first clk of each PWM period

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset is rst, asynchronous, active-high.
  - All configuration inputs are synchronous to clk; no CDC inside the block.
- Reset values: prescaler=0, pwm_cnt=0, duty_active=0x00, out=16'h0000, period_start=0.
- Timebase:
  - Prescaler counts 0..PRESCALE-1 and wraps to 0.
  - tick = (prescaler == PRESCALE-1).
  - On tick, pwm_cnt increments mod 256 (255 -> 0).
  - PRESCALE=1 gives tick every cycle.
- Period boundary:
  - wrap = tick && pwm_cnt==255.
  - period_start is registered from wrap, so it is high in the cycle where pwm_cnt first reads 0.
  - After reset release, the first period_start occurs 256*PRESCALE cycles later. No pulse at reset exit.
- PWM level (combinational from current state):
  - duty_active==0xFF -> 1.
  - Otherwise -> (pwm_cnt < duty_active), unsigned 8-bit compare.
  - High time per period = duty*PRESCALE clk cycles for duty 0..254. Duty 0 is never high; 0xFF is never low.
- Per-bit output select, i = 0..15, with en_out/en_pwm = the concatenated {15_8, 7_0} vectors:
  - en_out[i]=0 -> 0.
  - en_out[i]=1, en_pwm[i]=0 -> 1.
  - en_out[i]=1, en_pwm[i]=1 -> pwm_level.
- Latency: out is registered. A change on any en_* input, or on pwm_cnt, is visible on out exactly 1 clk later.
- Simultaneous events:
  - A duty change in the same cycle as wrap takes the new value; see the Optional Feature for duty-load timing.
  - Enable changes are never deferred.
- Reset mid-period: out drops to 0 immediately (asynchronous). Counters restart from 0 on release.

Optional Feature:
- Macro: PWM_SYNC_UPDATE_EN
- Defined:
  - duty_active is a shadow register loaded from pwm_duty_cycle only in the cycle where wrap=1.
  - Mid-period writes have no effect until the next period.
  - A write coincident with wrap is taken.
- Undefined:
  - duty_active is pwm_duty_cycle directly, with no register.
  - A duty change affects the compare in the same cycle and is visible on out 1 clk later, possibly producing one irregular period.

Decomposition:
- Package pwm_pkg:
  - constant PWM_CNT_W=8
  - constant DUTY_FULL=8'hFF
  - constant DEFAULT_PRESCALE=13
  - typedef pwm_cnt_t (logic [7:0])
- Sub-module pwm_timebase (parameters PRESCALE, PRESCALE_W):
  - Prescaler plus pwm_cnt.
  - Outputs pwm_cnt and wrap.
- The top module holds the duty shadow, compare, output mask register and period_start register.

Test Plan:
- Reset check: assert rst mid-run -> out=0x0000 within the same cycle, period_start=0. Release -> first period_start after 256*13=3328 clks.
- Duty 50%: all en_* = 0xFF, duty=0x80, PRESCALE=13 -> every out bit high 1664 clks, low 1664 clks per 3328-clk period, all bits in phase.
- Duty extremes: duty=0x00 -> out constantly 0x0000 across 2 periods. duty=0xFF -> constantly 0xFFFF. duty=0x01 -> high exactly 13 clks per period.
- Masking: en_out=0x00F0 / 0x0F00, en_pwm=0x0030 / 0x0000, duty=0x40 -> bits 4,5 PWM at 25%, bits 6,7 static 1, out[15:8] = 0x0F static, all others 0. An en_out bit cleared -> that out bit falls 1 clk later.
- Duty update timing: duty 0x20 -> 0xC0 written at pwm_cnt=0x50.
  - PWM_SYNC_UPDATE_EN defined: current period keeps 0x20; next period is 0xC0, starting at period_start.
  - Undefined: out goes high again 1 clk after the write.
- Coincident write: duty write in the wrap cycle with PWM_SYNC_UPDATE_EN -> new duty applies to the period beginning at that period_start.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM peripheral.
package pwm_pkg;

    localparam int         PWM_CNT_W        = 8;
    localparam logic [7:0] DUTY_FULL        = 8'hFF;
    localparam int         DEFAULT_PRESCALE = 13;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM timebase; wrap_o flags the last clk of each PWM period.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE   = DEFAULT_PRESCALE,
    parameter int PRESCALE_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    output pwm_cnt_t pwm_cnt_o,
    output logic     wrap_o
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
    pwm_cnt_t              pwmCnt_q, pwmCnt_d;
    logic                  tick;

    always_comb begin
        tick        = (prescaler_q == PRESCALE_LAST);
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        pwmCnt_d    = tick ? pwmCnt_q + 1'b1 : pwmCnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
            pwmCnt_q    <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            pwmCnt_q    <= pwmCnt_d;
        end
    end

    assign pwm_cnt_o = pwmCnt_q;
    assign wrap_o    = tick && (pwmCnt_q == pwm_cnt_t'(8'hFF));

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: per-pin low / high / shared-PWM select, registered outputs.
// Define PWM_SYNC_UPDATE_EN to defer duty changes to the next period boundary.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE   = DEFAULT_PRESCALE,
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    pwm_cnt_t    pwmCnt;
    logic        wrap;
    logic [7:0]  dutyActive;
    logic        pwmLevel;
    logic [15:0] enOut, enPwm;
    logic [15:0] outMask_q, outMask_d;
    logic        periodStart_q;

    pwm_timebase #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .pwm_cnt_o (pwmCnt),
        .wrap_o    (wrap)
    );

`ifdef PWM_SYNC_UPDATE_EN
    logic [7:0] duty_q, duty_d;

    // Shadow only reloads at the period boundary so every period is regular.
    always_comb begin
        duty_d = wrap ? pwm_duty_cycle : duty_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign dutyActive = duty_q;
`else
    assign dutyActive = pwm_duty_cycle;
`endif

    always_comb begin
        enOut     = {en_reg_out_15_8, en_reg_out_7_0};
        enPwm     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        pwmLevel  = (dutyActive == DUTY_FULL) ? 1'b1 : (pwmCnt < dutyActive);
        outMask_d = enOut & (~enPwm | {16{pwmLevel}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outMask_q     <= '0;
            periodStart_q <= 1'b0;
        end else begin
            outMask_q     <= outMask_d;
            periodStart_q <= wrap;
        end
    end

    assign out          = outMask_q;
    assign period_start = periodStart_q;

endmodule
